// File: rtl/uart_telemetry_framer_pkg.sv
// rtl/uart_telemetry_framer_pkg.sv - shared types and frame geometry for the telemetry framer
package uart_telem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam int          HEADER_LEN = 4;
  localparam logic [31:0] HEADER     = 32'hFF00_00FF;
  localparam logic [7:0]  TRAILER    = 8'hFF;

  function automatic int frame_len(input int num_ch);
    return 3 * num_ch + 6;
  endfunction

  function automatic int period_cyc(input int clk_fre, input int period_ms);
    return clk_fre * 1000 * period_ms;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with show-ahead read data, used as the echo buffer
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !full_o) begin
      mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en_i && !full_o) begin
        wptr_q <= wptr_q + (AW+1)'(1);
      end
      if (rd_en_i && !empty_o) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_telemetry_framer.sv
// rtl/uart_telemetry_framer.sv - periodic checksummed sample framer with host-byte echo
module uart_telemetry_framer
  import uart_telem_pkg::*;
#(
  parameter int CLK_FRE    = 100,
  parameter int NUM_CH     = 2,
  parameter int SAMPLE_W   = 12,
  parameter int PERIOD_MS  = 1000,
  parameter int ECHO_DEPTH = 16
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       enable,
  input  logic [NUM_CH*SAMPLE_W-1:0] samples_in,
  output logic [7:0]                 tx_data,
  output logic                       tx_data_valid,
  input  logic                       tx_data_ready,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_data_valid,
  output logic                       rx_data_ready,
  output logic                       frame_done,
  output logic [15:0]                frame_cnt,
  output logic                       echo_ovf,
  output logic                       frame_overrun
);

  localparam int FLEN  = frame_len(NUM_CH);
  localparam int PCYC  = period_cyc(CLK_FRE, PERIOD_MS);
  localparam int IDX_W = $clog2(FLEN);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W = $clog2(PCYC) + 1;

  localparam logic [IDX_W-1:0] IDX_HDR_END = IDX_W'(HEADER_LEN);
  localparam logic [IDX_W-1:0] IDX_CHK     = IDX_W'(FLEN - 2);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(FLEN - 1);
  localparam logic [TMR_W-1:0] TMR_EXPIRE  = TMR_W'(PCYC - 1);

  state_t           state_q;
  logic [15:0]      snap_q [NUM_CH];
  logic [IDX_W-1:0] idx_q;
  logic [CH_W-1:0]  ch_q;
  logic [1:0]       sub_q;
  logic [7:0]       chk_q;
  logic [TMR_W-1:0] tmr_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic             frame_done_q;
  logic [15:0]      frame_cnt_q;
  logic             echo_ovf_q;
  logic             overrun_q;

  logic [7:0] byte_d;
  logic       pop_d;
  logic       is_ch_byte;
  logic       expired;
  logic       tx_accept;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;

  assign expired    = (tmr_q == TMR_EXPIRE);
  assign tx_accept  = tx_valid_q && tx_data_ready;
  assign is_ch_byte = (idx_q >= IDX_HDR_END) && (idx_q < IDX_CHK);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (ECHO_DEPTH)
  ) u_echo_fifo (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .wr_en_i   (rx_data_valid),
    .wr_data_i (rx_data),
    .rd_en_i   (pop_d),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    byte_d = TRAILER;
    if (idx_q < IDX_HDR_END) begin
      case (idx_q[1:0])
        2'd0:    byte_d = HEADER[31:24];
        2'd1:    byte_d = HEADER[23:16];
        2'd2:    byte_d = HEADER[15:8];
        default: byte_d = HEADER[7:0];
      endcase
    end else if (idx_q == IDX_CHK) begin
      byte_d = chk_q;
    end else if (is_ch_byte) begin
      case (sub_q)
        2'd0:    byte_d = 8'(ch_q);
        2'd1:    byte_d = snap_q[ch_q][15:8];
        default: byte_d = snap_q[ch_q][7:0];
      endcase
    end
  end

  // Echo only between frames; in WAIT a reached expiry blocks further pops.
  always_comb begin
    pop_d = 1'b0;
    if (!tx_valid_q && !fifo_empty) begin
      if (state_q == ST_WAIT && !expired) pop_d = 1'b1;
      if (state_q == ST_IDLE && !enable)  pop_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      for (int k = 0; k < NUM_CH; k++) snap_q[k] <= '0;
      idx_q        <= '0;
      ch_q         <= '0;
      sub_q        <= '0;
      chk_q        <= '0;
      tmr_q        <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      echo_ovf_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (rx_data_valid && fifo_full)    echo_ovf_q <= 1'b1;
      if (state_q == ST_SEND && expired) overrun_q  <= 1'b1;
      if (state_q == ST_LATCH)           tmr_q      <= TMR_W'(1);
      else if (!expired)                 tmr_q      <= tmr_q + TMR_W'(1);
      if (tx_accept)                     tx_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (pop_d) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= fifo_rdata;
          end else if (!tx_valid_q && enable) begin
            state_q <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          for (int k = 0; k < NUM_CH; k++) begin
            snap_q[k] <= 16'(samples_in[k*SAMPLE_W +: SAMPLE_W]);
          end
          idx_q   <= '0;
          ch_q    <= '0;
          sub_q   <= '0;
          chk_q   <= '0;
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_accept) begin
            if (idx_q == IDX_LAST) begin
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 16'd1;
              state_q      <= ST_WAIT;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
            if (is_ch_byte) begin
              chk_q <= chk_q + tx_data_q;
              if (sub_q == 2'd2) begin
                sub_q <= 2'd0;
                ch_q  <= ch_q + CH_W'(1);
              end else begin
                sub_q <= sub_q + 2'd1;
              end
            end
          end else if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= byte_d;
          end
        end
        default: begin
          if (pop_d) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= fifo_rdata;
          end else if (!tx_valid_q && expired) begin
            state_q <= enable ? ST_LATCH : ST_IDLE;
          end
        end
      endcase
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign rx_data_ready = !fifo_full;
  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;
  assign echo_ovf      = echo_ovf_q;
  assign frame_overrun = overrun_q;

endmodule
